// File: rtl/gcd_rr_arbiter.sv
// -----------------------------------------------------------------------------
// gcd_rr_arbiter
//
// Round-robin front end that shares one subtraction-based GCD engine among N
// requesters. One request is in flight at a time: the winner's operand pair is
// captured, the engine is launched through its start/ready handshake, and the
// result returns tagged with the requester id over a valid/ready port.
// Requests with a zero operand are answered locally (result = a|b), because
// the subtraction engine never terminates on a zero operand.
//
// Optional feature macro: GCD_LAT_CNT_EN
//   When defined, adds output rsp_cycles[15:0]: cycles spent in ISSUE/WAIT
//   between the grant pulse and the response, saturating at 16'hFFFF.
//
// Ports:
//   clk        clock, all state updates on posedge
//   nrst       asynchronous active-low reset
//   req        per-requester request level, held until its grant bit pulses
//   req_a      operand A of requester i at [i*W +: W]
//   req_b      operand B of requester i at [i*W +: W]
//   grant      one-hot 1-cycle pulse: operands of requester i were captured
//   rsp_valid  result available
//   rsp_ready  consumer accepts result
//   rsp_id     requester index of the result
//   rsp_data   gcd(a,b)
//   eng_start  engine start, 1-cycle pulse
//   eng_a      engine operand A (captured register)
//   eng_b      engine operand B (captured register)
//   eng_ready  engine idle/done (1 = READY, 0 = BUSY)
//   eng_out    engine result, valid while eng_ready=1 after completion
//   rsp_cycles (GCD_LAT_CNT_EN only) grant-to-response cycle count
// -----------------------------------------------------------------------------
module gcd_rr_arbiter #(
    parameter int N   = 4,
    parameter int W   = 8,
    parameter int IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           nrst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] req_a,
    input  logic [N*W-1:0] req_b,
    output logic [N-1:0]   grant,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [IDW-1:0] rsp_id,
    output logic [W-1:0]   rsp_data,
    output logic           eng_start,
    output logic [W-1:0]   eng_a,
    output logic [W-1:0]   eng_b,
    input  logic           eng_ready,
    input  logic [W-1:0]   eng_out
`ifdef GCD_LAT_CNT_EN
    ,
    output logic [15:0]    rsp_cycles
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [N-1:0]   r_grant;
    logic           r_rsp_valid;
    logic [IDW-1:0] r_cur_id;
    logic [IDW-1:0] r_rr_ptr;
    logic [W-1:0]   r_rsp_data;
    logic [W-1:0]   r_op_a;
    logic [W-1:0]   r_op_b;
    logic           r_armed;

    logic [IDW-1:0] w_sel_id;
    logic [W-1:0]   w_sel_a;
    logic [W-1:0]   w_sel_b;
    logic           w_bypass;
    logic           w_capture;
    logic           w_eng_start;
    logic           w_eng_done;
    logic           w_rsp_hs;

    // Round-robin pick. Offsets are scanned from farthest to nearest so the
    // last hit, i.e. the requester nearest after r_rr_ptr, wins.
    always_comb begin
        int v_idx;
        v_idx    = 0;
        w_sel_id = '0;
        for (int k = N; k >= 1; k--) begin
            v_idx = (int'(r_rr_ptr) + k) % N;
            if (req[v_idx]) begin
                w_sel_id = IDW'(v_idx);
            end
        end
    end

    assign w_sel_a  = req_a[int'(w_sel_id)*W +: W];
    assign w_sel_b  = req_b[int'(w_sel_id)*W +: W];
    assign w_bypass = (w_sel_a == '0) || (w_sel_b == '0);

    // Next-state and handshake decode
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_eng_start = 1'b0;
        w_eng_done  = 1'b0;
        w_rsp_hs    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_capture   = 1'b1;
                    w_state_nxt = w_bypass ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (eng_ready) begin
                    w_eng_start = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // Only a ready seen after the engine has gone busy is a completion.
                if (r_armed && eng_ready) begin
                    w_eng_done  = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (r_rsp_valid && rsp_ready) begin
                    w_rsp_hs    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_grant     <= '0;
            r_rsp_valid <= 1'b0;
            r_cur_id    <= '0;
            r_rr_ptr    <= IDW'(N - 1);
            r_rsp_data  <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_armed     <= 1'b0;
        end else begin
            r_grant <= '0;
            if (w_capture) begin
                r_grant  <= N'(1) << w_sel_id;
                r_op_a   <= w_sel_a;
                r_op_b   <= w_sel_b;
                r_cur_id <= w_sel_id;
                if (w_bypass) begin
                    r_rsp_data <= w_sel_a | w_sel_b;
                end
            end
            if (w_eng_start) begin
                r_armed <= 1'b0;
            end
            if (r_state == S_WAIT && !eng_ready) begin
                r_armed <= 1'b1;
            end
            if (w_eng_done) begin
                r_rsp_data  <= eng_out;
                r_rsp_valid <= 1'b1;
            end
            // Bypassed requests enter RESP with valid low; raise it one cycle later.
            if (r_state == S_RESP && !r_rsp_valid) begin
                r_rsp_valid <= 1'b1;
            end
            if (w_rsp_hs) begin
                r_rsp_valid <= 1'b0;
                r_rr_ptr    <= r_cur_id;
            end
        end
    end

`ifdef GCD_LAT_CNT_EN
    logic [15:0] r_cycles;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cycles <= '0;
        end else if (w_capture) begin
            r_cycles <= '0;
        end else if ((r_state == S_ISSUE || r_state == S_WAIT) && r_cycles != 16'hFFFF) begin
            r_cycles <= r_cycles + 16'd1;
        end
    end

    assign rsp_cycles = r_cycles;
`endif

    assign grant     = r_grant;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_cur_id;
    assign rsp_data  = r_rsp_data;
    assign eng_start = w_eng_start;
    assign eng_a     = r_op_a;
    assign eng_b     = r_op_b;

endmodule

// File: tb/tb_gcd_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_gcd_rr_arbiter
//
// Bench for gcd_rr_arbiter with a behavioural subtraction GCD engine attached.
// Table-driven single transactions, hand-written corner sequences and a
// randomized phase checked against a round-robin / Euclid reference model.
// -----------------------------------------------------------------------------
module tb_gcd_rr_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           nrst = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N-1:0]   grant;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [IDW-1:0] rsp_id;
    logic [W-1:0]   rsp_data;
    logic           eng_start;
    logic [W-1:0]   eng_a;
    logic [W-1:0]   eng_b;
    logic           eng_ready;
    logic [W-1:0]   eng_out;
`ifdef GCD_LAT_CNT_EN
    logic [15:0]    rsp_cycles;
`endif

    always #5 clk = ~clk;

    gcd_rr_arbiter #(.N(N), .W(W), .IDW(IDW)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .req       (req),
        .req_a     (req_a),
        .req_b     (req_b),
        .grant     (grant),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .eng_start (eng_start),
        .eng_a     (eng_a),
        .eng_b     (eng_b),
        .eng_ready (eng_ready),
        .eng_out   (eng_out)
`ifdef GCD_LAT_CNT_EN
        ,
        .rsp_cycles(rsp_cycles)
`endif
    );

    // Behavioural subtraction GCD engine. stale_mode delays going busy by one
    // cycle so ready stays high in the first cycle after start is accepted.
    logic       hold_busy = 1'b0;
    logic       stale_mode = 1'b0;
    logic       e_busy, e_pend;
    logic [W-1:0] e_x, e_y, e_out;

    assign eng_ready = ~e_busy & ~hold_busy;
    assign eng_out   = e_out;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            e_busy <= 1'b0; e_pend <= 1'b0; e_x <= '0; e_y <= '0; e_out <= 8'hEE;
        end else if (e_pend) begin
            e_pend <= 1'b0; e_busy <= 1'b1;
        end else if (e_busy) begin
            if (e_x == e_y) begin
                e_busy <= 1'b0; e_out <= e_x;
            end else if (e_x > e_y) begin
                e_x <= e_x - e_y;
            end else begin
                e_y <= e_y - e_x;
            end
        end else if (eng_start && eng_ready) begin
            e_x <= eng_a; e_y <= eng_b;
            if (stale_mode) e_pend <= 1'b1;
            else            e_busy <= 1'b1;
        end
    end

    int n_grants = 0;
    int n_starts = 0;
    always @(posedge clk) begin
        if (|grant)                n_grants <= n_grants + 1;
        if (eng_start && eng_ready) n_starts <= n_starts + 1;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int gcd_ref(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b; a = b; b = t;
        end
        return a;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 1; k <= N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic set_lane(input int i, input int a, input int b);
        req_a[i*W +: W] = W'(a);
        req_b[i*W +: W] = W'(b);
    endtask

    task automatic wait_grant(input int lim);
        int c;
        c = 0;
        while (grant == '0 && c < lim) begin
            tick(); c++;
        end
    endtask

    task automatic wait_rsp(input int lim, output int lat);
        lat = 0;
        while (!rsp_valid && lat < lim) begin
            tick(); lat++;
        end
    endtask

    task automatic finish_rsp(input string nm, input int id, input int d);
        int lat;
        wait_rsp(600, lat);
        check({nm, "_valid"}, rsp_valid, 1);
        check({nm, "_id"}, rsp_id, id);
        check({nm, "_data"}, rsp_data, d);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic do_reset();
        nrst = 1'b0; req = '0; rsp_ready = 1'b0; hold_busy = 1'b0; stale_mode = 1'b0;
        tick(); tick();
        nrst = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0] r;
        int           a;
        int           b;
        int           id;
        int           d;
        bit           byp;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int g0, s0, lat, bad, ptr, exp_id, exp_d, pid, pd, nrsp, w, av, bv;
        bit outst, pv, rdy;

        tbl[0] = '{4'b0001, 48, 18, 0, 6, 1'b0};
        tbl[1] = '{4'b0100, 0, 25, 2, 25, 1'b1};
        tbl[2] = '{4'b0100, 0, 0, 2, 0, 1'b1};
        tbl[3] = '{4'b1000, 200, 0, 3, 200, 1'b1};
        tbl[4] = '{4'b0010, 255, 255, 1, 255, 1'b0};
        tbl[5] = '{4'b1000, 1, 255, 3, 1, 1'b0};
        tbl[6] = '{4'b0001, 100, 75, 0, 25, 1'b0};

        // Reset state, with requests pending while reset is held
        nrst = 1'b0;
        set_lane(0, 48, 18);
        req = 4'b1111;
        tick(); tick();
        check("rst_grant", grant, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_eng_start", eng_start, 0);
        check("rst_eng_a", eng_a, 0);
        check("rst_eng_b", eng_b, 0);
        req = '0;
        nrst = 1'b1;
        tick();

        // Table-driven single transactions
        for (int t = 0; t < 7; t++) begin
            g0 = n_grants; s0 = n_starts;
            set_lane(tbl[t].id, tbl[t].a, tbl[t].b);
            req = tbl[t].r;
            wait_grant(20);
            check($sformatf("tbl%0d_grant", t), grant, 1 << tbl[t].id);
            req = '0;
            wait_rsp(600, lat);
            check($sformatf("tbl%0d_valid", t), rsp_valid, 1);
            check($sformatf("tbl%0d_id", t), rsp_id, tbl[t].id);
            check($sformatf("tbl%0d_data", t), rsp_data, tbl[t].d);
            if (tbl[t].byp) check($sformatf("tbl%0d_bypass_lat", t), lat, 1);
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            check($sformatf("tbl%0d_valid_drop", t), rsp_valid, 0);
            check($sformatf("tbl%0d_grants", t), n_grants - g0, 1);
            check($sformatf("tbl%0d_starts", t), n_starts - s0, tbl[t].byp ? 0 : 1);
        end

        // Contention from reset: 0,1,2,3 then 0 again
        do_reset();
        set_lane(0, 12, 8); set_lane(1, 9, 6); set_lane(2, 35, 14); set_lane(3, 7, 5);
        req = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_grant(20);
            check($sformatf("cont%0d_grant", k), grant, 1 << k);
            wait_rsp(600, lat);
            check($sformatf("cont%0d_id", k), rsp_id, k);
            check($sformatf("cont%0d_data", k), rsp_data, gcd_ref((k == 0) ? 12 : (k == 1) ? 9 : (k == 2) ? 35 : 7,
                                                                   (k == 0) ? 8 : (k == 1) ? 6 : (k == 2) ? 14 : 5));
            tick();
        end
        wait_grant(20);
        check("cont4_grant", grant, 1);
        req = '0;
        rsp_ready = 1'b0;
        finish_rsp("cont4", 0, 4);

        // Backpressure with another requester waiting
        set_lane(0, 100, 75); set_lane(1, 9, 6);
        req = 4'b0001;
        wait_grant(20);
        check("bp_grant", grant, 1);
        req = 4'b0010;
        wait_rsp(600, lat);
        check("bp_valid", rsp_valid, 1);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (!rsp_valid || rsp_data != 8'd25 || rsp_id != 0 || grant != 0 || eng_start) bad++;
            tick();
        end
        check("bp_hold_stable", bad, 0);
        check("bp_data", rsp_data, 25);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("bp_release_drop", rsp_valid, 0);
        wait_grant(20);
        check("bp_next_grant", grant, 2);
        req = '0;
        finish_rsp("bp_next", 1, 3);

        // Engine not ready on entering ISSUE, then stale ready in first WAIT cycle
        hold_busy = 1'b1;
        set_lane(2, 21, 14);
        req = 4'b0100;
        wait_grant(20);
        check("nr_grant", grant, 4);
        req = '0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (eng_start) bad++;
            tick();
        end
        check("nr_start_suppressed", bad, 0);
        hold_busy = 1'b0;
        stale_mode = 1'b1;
        #1;
        check("nr_start_on_ready", eng_start, 1);
        finish_rsp("nr_stale", 2, 7);
        stale_mode = 1'b0;

        // Reset during WAIT; afterwards requester 1 alone, then 0 vs 1
        set_lane(0, 200, 150); set_lane(1, 9, 6);
        req = 4'b0001;
        wait_grant(20);
        check("rw_grant", grant, 1);
        req = '0;
        tick(); tick(); tick();
        nrst = 1'b0;
        #1;
        check("rw_rsp_valid", rsp_valid, 0);
        check("rw_grant_clr", grant, 0);
        check("rw_eng_start", eng_start, 0);
        check("rw_eng_a", eng_a, 0);
        req = 4'b0010;
        tick();
        nrst = 1'b1;
        wait_grant(20);
        check("rw_req1_only", grant, 2);
        req = '0;
        finish_rsp("rw_req1", 1, 3);
        nrst = 1'b0;
        req = 4'b0011;
        tick();
        nrst = 1'b1;
        wait_grant(20);
        check("rw_req0_wins", grant, 1);
        req = '0;
        finish_rsp("rw_req0", 0, 50);

        // Randomized traffic against the reference model
        do_reset();
        ptr = N - 1; outst = 0; pv = 0; pid = 0; pd = 0; nrsp = 0; exp_id = 0; exp_d = 0;
        for (int c = 0; c < 9000; c++) begin
            if (c < 5000) begin
                for (int i = 0; i < N; i++) begin
                    if (!req[i] && $urandom_range(0, 3) == 0) begin
                        av = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
                        bv = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
                        set_lane(i, av, bv);
                        req[i] = 1'b1;
                    end
                end
            end
            rdy = ($urandom_range(0, 2) != 0);
            rsp_ready = rdy;
            tick();
            if (pv && rdy) begin
                check("rnd_rsp_id", pid, exp_id);
                check("rnd_rsp_data", pd, exp_d);
                ptr = exp_id; outst = 0; nrsp++;
            end
            if (grant != '0) begin
                w = rr_pick(req, ptr);
                check("rnd_grant", grant, (w < 0) ? 0 : (1 << w));
                check("rnd_one_in_flight", outst, 0);
                if (w >= 0) begin
                    exp_id = w;
                    exp_d  = gcd_ref(req_a[w*W +: W], req_b[w*W +: W]);
                    req[w] = 1'b0;
                end
                outst = 1;
            end else if (!outst) begin
                check("rnd_no_spurious_rsp", rsp_valid, 0);
            end
            pv = rsp_valid; pid = rsp_id; pd = rsp_data;
            if (c >= 5000 && req == '0 && !outst) break;
        end
        rsp_ready = 1'b0;
        check("rnd_drained", int'(outst) + int'(|req), 0);
        check("rnd_enough_rsps", (nrsp > 10) ? 1 : 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
